// File: rtl/aes_pkg.sv
// AES byte/state helpers, S-box tables and FSM encoding shared by the AES encrypt and decrypt cores.
// Byte n of a 128-bit block (bits [127-8n -: 8]) maps to state[n%4][n/4], column-major.
package aes_pkg;

  typedef logic [3:0][3:0][7:0] state_t;  // [row][col]

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEXP,
    ST_INIT,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } dec_state_e;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Entry b sits at bits [2047-8b -: 8]; 2047-8b == {~b, 3'b111}.
  function automatic logic [7:0] sbox_lu(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox_lu(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_lu(w[31:24]), sbox_lu(w[23:16]), sbox_lu(w[15:8]), sbox_lu(w[7:0])};
  endfunction

  function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic state_t to_state(input logic [127:0] w);
    state_t s;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = w[127 - 8*(4*c + r) -: 8];
    return s;
  endfunction

  function automatic logic [127:0] from_state(input state_t s);
    logic [127:0] w;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        w[127 - 8*(4*c + r) -: 8] = s[r][c];
    return w;
  endfunction

  // Row r rotates right by r columns.
  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[r][c] = s[r][(c + 4 - r) % 4];
    return o;
  endfunction

  function automatic state_t inv_sub_bytes(input state_t s);
    state_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[r][c] = inv_sbox_lu(s[r][c]);
    return o;
  endfunction

  function automatic state_t inv_mix_columns(input state_t s);
    state_t o;
    for (int c = 0; c < 4; c++) begin
      o[0][c] = gmul(s[0][c], 8'h0e) ^ gmul(s[1][c], 8'h0b) ^ gmul(s[2][c], 8'h0d) ^ gmul(s[3][c], 8'h09);
      o[1][c] = gmul(s[0][c], 8'h09) ^ gmul(s[1][c], 8'h0e) ^ gmul(s[2][c], 8'h0b) ^ gmul(s[3][c], 8'h0d);
      o[2][c] = gmul(s[0][c], 8'h0d) ^ gmul(s[1][c], 8'h09) ^ gmul(s[2][c], 8'h0e) ^ gmul(s[3][c], 8'h0b);
      o[3][c] = gmul(s[0][c], 8'h0b) ^ gmul(s[1][c], 8'h0d) ^ gmul(s[2][c], 8'h09) ^ gmul(s[3][c], 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round, purely combinational (0 cycles, no handshake).
// last=1 drops InvMixColumns for the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] next_state
);

  state_t       sub_s;
  state_t       mix_s;
  logic [127:0] ark;

  always_comb begin
    sub_s      = inv_sub_bytes(inv_shift_rows(to_state(state)));
    ark        = from_state(sub_s) ^ rk;
    mix_s      = inv_mix_columns(to_state(ark));
    next_state = last ? ark : from_state(mix_s);
  end

endmodule

// File: rtl/aes128_decrypt.sv
// Iterative AES-128 inverse cipher: 21 enabled cycles accept->out_valid (11 on a key-cache hit).
// in_ready only in IDLE, result held until out_ready; AES_DEC_KEY_CACHE_EN keeps round keys across blocks.
module aes128_decrypt
  import aes_pkg::*;
#(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [KEY_W-1:0] key,
  input  logic [127:0]     cipher,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     plain
);

  if (NR != 10 || KEY_W != 128) begin : g_bad_cfg
    $error("aes128_decrypt supports only NR=10 and KEY_W=128");
  end

  dec_state_e       fsm;
  logic [3:0]       rnd;
  logic [127:0]     st;
  logic [KEY_W-1:0] rk [0:NR];
  logic [127:0]     rnd_out;
`ifdef AES_DEC_KEY_CACHE_EN
  logic             key_vld;
`endif

  // rnd doubles as the round-key index: 1..10 while expanding, 9..1 in ROUND, 0 in FINAL.
  aes_inv_round u_inv_round (
    .state      (st),
    .rk         (rk[rnd]),
    .last       (fsm == ST_FINAL),
    .next_state (rnd_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm       <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      plain     <= '0;
      rnd       <= '0;
      st        <= '0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
      key_vld   <= 1'b0;
`endif
    end else if (en) begin
      case (fsm)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            st       <= cipher;
            in_ready <= 1'b0;
            rnd      <= 4'd1;
`ifdef AES_DEC_KEY_CACHE_EN
            if (key_vld && key == rk[0]) begin
              fsm <= ST_INIT;
            end else begin
              rk[0]   <= key;
              key_vld <= 1'b0;
              fsm     <= ST_KEXP;
            end
`else
            rk[0] <= key;
            fsm   <= ST_KEXP;
`endif
          end
        end
        ST_KEXP: begin
          rk[rnd] <= expand_key(rk[rnd - 4'd1], rcon(rnd));
          if (rnd == 4'(NR)) begin
            fsm <= ST_INIT;
`ifdef AES_DEC_KEY_CACHE_EN
            key_vld <= 1'b1;
`endif
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        ST_INIT: begin
          st  <= st ^ rk[NR];
          rnd <= 4'(NR - 1);
          fsm <= ST_ROUND;
        end
        ST_ROUND: begin
          st <= rnd_out;
          if (rnd == 4'd1) begin
            rnd <= 4'd0;
            fsm <= ST_FINAL;
          end else begin
            rnd <= rnd - 4'd1;
          end
        end
        ST_FINAL: begin
          plain     <= rnd_out;
          out_valid <= 1'b1;
          fsm       <= ST_DONE;
        end
        ST_DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            fsm       <= ST_IDLE;
          end
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule
